// File: rtl/uart_pkg.sv
// Shared UART constants: state encoding, default line settings and bit-period helper.
// Both the receiver and the transmitter use these definitions.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUDRATE = 115200;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_START = START,
        ST_DATA  = DATA,
        ST_STOP  = STOP,
        ST_BREAK = BREAK
    } rx_state_t;

    function automatic int clk_perbit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Both flops reset to RESET_VALUE so an idle line produces no false edge.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] ff_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_reg <= {2{RESET_VALUE}};
        end else begin
            ff_reg <= {ff_reg[0], d};
        end
    end

    assign q = ff_reg[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, valid/frame-error pulses and break handling.
// A low stop bit parks the FSM in BREAK until the line returns high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUDRATE   = DEFAULT_BAUDRATE,
    parameter int CLK_PERBIT = clk_perbit(CLK_FREQ, BAUDRATE),
    parameter int HALF_BIT   = CLK_PERBIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam logic [15:0] HALF_LAST   = 16'(HALF_BIT - 1);
    localparam logic [15:0] PERBIT_LAST = 16'(CLK_PERBIT - 1);

    logic rx_s;

    rx_state_t   state_reg, state_next;
    logic [15:0] count_reg, count_next;
    logic [2:0]  bit_count_reg, bit_count_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  data_reg, data_next;
    logic        valid_reg, valid_next;
    logic        err_reg, err_next;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_serial),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            count_reg     <= 16'd0;
            bit_count_reg <= 3'd0;
            shift_reg     <= 8'd0;
            data_reg      <= 8'd0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            bit_count_reg <= bit_count_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        bit_count_next = bit_count_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        err_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                count_next     = 16'd0;
                bit_count_next = 3'd0;
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end

            // A start bit that is already high again at its midpoint is a glitch.
            ST_START: begin
                if (count_reg == HALF_LAST) begin
                    count_next = 16'd0;
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    count_next = count_reg + 16'd1;
                end
            end

            ST_DATA: begin
                if (count_reg == PERBIT_LAST) begin
                    count_next = 16'd0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    if (bit_count_reg == 3'd7) begin
                        bit_count_next = 3'd0;
                        state_next     = ST_STOP;
                    end else begin
                        bit_count_next = bit_count_reg + 3'd1;
                    end
                end else begin
                    count_next = count_reg + 16'd1;
                end
            end

            // Leaving at mid-stop-bit leaves half a bit to catch a following start edge.
            ST_STOP: begin
                if (count_reg == PERBIT_LAST) begin
                    count_next = 16'd0;
                    if (rx_s) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_BREAK;
                    end
                end else begin
                    count_next = count_reg + 16'd1;
                end
            end

            ST_BREAK: begin
                count_next = 16'd0;
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rx_data      = data_reg;
    assign rx_valid     = valid_reg;
    assign rx_frame_err = err_reg;
    assign rx_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: behavioural line driver, pulse monitor and
// expected bytes/latencies derived from the frame timing rules.
module tb_uart_rx;

    localparam int CLK_FREQ = 10_000_000;
    localparam int BAUDRATE = 100_000;
    localparam int CPB      = CLK_FREQ / BAUDRATE;
    localparam int HALF     = CPB / 2;
    localparam int LAT      = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;

    logic [7:0] got_data[$];
    longint     got_cyc[$];
    longint     err_cyc[$];
    int         both_cnt = 0;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUDRATE (BAUDRATE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_data.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
        if (rx_frame_err) err_cyc.push_back(cyc);
        if (rx_valid && rx_frame_err) both_cnt++;
    end

    task automatic clear_mon();
        got_data.delete();
        got_cyc.delete();
        err_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; drives start, 8 data bits LSB first and the stop bit.
    task automatic send_frame(input logic [7:0] b, input int perbit, input logic stop_bit,
                              output longint fall);
        logic [9:0] fr;
        fr   = {stop_bit, b, 1'b0};
        fall = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_serial = fr[i];
            repeat (perbit) @(negedge clk);
        end
    endtask

    task automatic check_one(input string name, input logic [7:0] exp_b, input longint fall,
                             input bit check_lat);
        total++;
        if (got_data.size() != 1) begin
            bad++;
            $display("FAIL %s count: got %0d valid pulses, want 1", name, got_data.size());
        end else begin
            total++;
            if (got_data[0] !== exp_b) begin
                bad++;
                $display("FAIL %s data: got %02h want %02h", name, got_data[0], exp_b);
            end
            if (check_lat) begin
                total++;
                if (got_cyc[0] - fall != LAT) begin
                    bad++;
                    $display("FAIL %s latency: got %0d want %0d", name, got_cyc[0] - fall, LAT);
                end
            end
        end
        total++;
        if (err_cyc.size() != 0) begin
            bad++;
            $display("FAIL %s frame_err: got %0d pulses want 0", name, err_cyc.size());
        end
        total++;
        if (rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy: got %b want 0", name, rx_busy);
        end
        $display("txn %s: sent %02h received %0d byte(s)", name, exp_b, got_data.size());
    endtask

    task automatic test_reset();
        #3;
        total += 4;
        if (rx_data !== 8'h00) begin bad++; $display("FAIL reset rx_data: got %02h want 00", rx_data); end
        if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset rx_valid: got %b want 0", rx_valid); end
        if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset rx_frame_err: got %b want 0", rx_frame_err); end
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset rx_busy: got %b want 0", rx_busy); end
        idle(4);
        rst_n = 1'b1;
        idle(10);
        $display("txn reset: outputs checked");
    endtask

    task automatic test_loopback();
        longint fall;
        clear_mon();
        send_frame(8'hA5, CPB, 1'b1, fall);
        rx_serial = 1'b1;
        idle(20);
        check_one("loopback_a5", 8'hA5, fall, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[3];
        longint     falls[3];
        seq = '{8'h00, 8'hFF, 8'h3C};
        clear_mon();
        for (int i = 0; i < 3; i++) send_frame(seq[i], CPB, 1'b1, falls[i]);
        rx_serial = 1'b1;
        idle(20);
        total++;
        if (got_data.size() != 3) begin
            bad++;
            $display("FAIL b2b count: got %0d want 3", got_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_data[i] !== seq[i]) begin
                    bad++;
                    $display("FAIL b2b data[%0d]: got %02h want %02h", i, got_data[i], seq[i]);
                end
                total++;
                if (got_cyc[i] - falls[0] != LAT + 10 * CPB * i) begin
                    bad++;
                    $display("FAIL b2b timing[%0d]: got %0d want %0d", i, got_cyc[i] - falls[0],
                             LAT + 10 * CPB * i);
                end
                $display("txn b2b[%0d]: sent %02h", i, seq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        longint     fall;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            clear_mon();
            send_frame(b, CPB, 1'b1, fall);
            rx_serial = 1'b1;
            idle(20 + int'($urandom_range(0, 2 * CPB)));
            check_one("random", b, fall, 1'b1);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] prior;
        int         len;
        prior = rx_data;
        len   = int'($urandom_range(5, HALF - 5));
        clear_mon();
        rx_serial = 1'b0;
        idle(len);
        rx_serial = 1'b1;
        idle(2);
        total++;
        if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch busy_during: got %b want 1", rx_busy); end
        idle(HALF + 10);
        total += 4;
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch busy_after: got %b want 0", rx_busy); end
        if (got_data.size() != 0) begin bad++; $display("FAIL glitch valid: got %0d pulses want 0", got_data.size()); end
        if (err_cyc.size() != 0) begin bad++; $display("FAIL glitch frame_err: got %0d pulses want 0", err_cyc.size()); end
        if (rx_data !== prior) begin bad++; $display("FAIL glitch rx_data: got %02h want %02h", rx_data, prior); end
        $display("txn glitch: low for %0d cycles", len);
    endtask

    task automatic test_stop_err();
        logic [7:0] prior;
        longint     fall;
        prior = rx_data;
        clear_mon();
        send_frame(8'h5A, CPB, 1'b0, fall);
        idle(3 * CPB);
        total++;
        if (err_cyc.size() != 1) begin
            bad++;
            $display("FAIL stop_err count: got %0d want 1", err_cyc.size());
        end else begin
            total++;
            if (err_cyc[0] - fall != LAT) begin
                bad++;
                $display("FAIL stop_err latency: got %0d want %0d", err_cyc[0] - fall, LAT);
            end
        end
        total += 3;
        if (got_data.size() != 0) begin bad++; $display("FAIL stop_err valid: got %0d want 0", got_data.size()); end
        if (rx_data !== prior) begin bad++; $display("FAIL stop_err rx_data: got %02h want %02h", rx_data, prior); end
        if (rx_busy !== 1'b1) begin bad++; $display("FAIL stop_err busy_low: got %b want 1", rx_busy); end
        rx_serial = 1'b1;
        idle(10);
        total++;
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL stop_err busy_high: got %b want 0", rx_busy); end
        $display("txn stop_err: sent 5A with low stop");
        clear_mon();
        send_frame(8'h81, CPB, 1'b1, fall);
        rx_serial = 1'b1;
        idle(20);
        check_one("after_err_81", 8'h81, fall, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [9:0] fr;
        longint     fall;
        fr = {1'b1, 8'($urandom_range(0, 255)), 1'b0};
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            rx_serial = fr[i];
            idle(CPB);
        end
        rx_serial = fr[5];
        idle(HALF);
        rst_n = 1'b0;
        #1;
        total += 4;
        if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid rx_data: got %02h want 00", rx_data); end
        if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid rx_valid: got %b want 0", rx_valid); end
        if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL rst_mid rx_frame_err: got %b want 0", rx_frame_err); end
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL rst_mid rx_busy: got %b want 0", rx_busy); end
        rx_serial = 1'b1;
        idle(4);
        rst_n = 1'b1;
        idle(2 * CPB);
        total++;
        if (got_data.size() + err_cyc.size() != 0) begin
            bad++;
            $display("FAIL rst_mid pulses: got %0d want 0", got_data.size() + err_cyc.size());
        end
        $display("txn reset_mid: aborted frame");
        clear_mon();
        send_frame(8'hC3, CPB, 1'b1, fall);
        rx_serial = 1'b1;
        idle(20);
        check_one("after_rst_c3", 8'hC3, fall, 1'b1);
    endtask

    task automatic test_baud();
        int     pb[2];
        longint fall;
        pb = '{CPB - CPB / 50, CPB + CPB / 50};
        for (int i = 0; i < 2; i++) begin
            clear_mon();
            send_frame(8'h96, pb[i], 1'b1, fall);
            rx_serial = 1'b1;
            idle(20);
            check_one("baud_96", 8'h96, fall, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_random();
        test_glitch();
        test_stop_err();
        test_reset_mid();
        test_baud();
        total++;
        if (both_cnt != 0) begin
            bad++;
            $display("FAIL exclusive pulses: got %0d overlapping cycles want 0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
